// File: rtl/ese_pac_pkg.sv
// ---------------------------------------------------------------------------
// ese_pac_pkg
//  Shared types and constants for the PAC cartridge front end and the
//  SRAM-unlock/bank decoder that consumes its qualified access strobes.
//  Contents:
//   pac_state_e   capture FSM states
//   acc_type_e    kind of access being qualified (write / read)
//   PAC_KEY_*     unlock key addresses and data values seen by the decoder
//   BANK1_SEL     bank-select code used once the SRAM is unlocked
// ---------------------------------------------------------------------------
package ese_pac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_QUAL     = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_WAIT_REL = 2'd3
   } pac_state_e;

   typedef enum logic {
      ACC_WR = 1'b0,
      ACC_RD = 1'b1
   } acc_type_e;

   localparam logic [15:0] PAC_KEY_A_ADDR = 16'h5FFE;
   localparam logic [7:0]  PAC_KEY_A_DATA = 8'h4D;
   localparam logic [15:0] PAC_KEY_B_ADDR = 16'h5FFF;
   localparam logic [7:0]  PAC_KEY_B_DATA = 8'h69;
   localparam logic [1:0]  BANK1_SEL      = 2'b01;

endpackage

// File: rtl/slot_sync.sv
// ---------------------------------------------------------------------------
// slot_sync
//  N-stage flop bank used to bring the slot bus into the SLT_CLOCK domain.
//  Every bit has its own reset value, so idle-high strobes come out of
//  reset at their inactive level.
//  Ports:
//   SLT_CLOCK  in   1   clock
//   SLT_RESET  in   1   synchronous, active-high reset
//   d          in   W   raw bus bits
//   q          out  W   bus bits delayed by N flops
// ---------------------------------------------------------------------------
module slot_sync #(
   parameter int unsigned     N       = 1,
   parameter int unsigned     W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic         SLT_CLOCK,
   input  logic         SLT_RESET,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [N];

   // NOTE: this is a handful of pipeline flops, not a RAM, so every stage is
   // reset; the FSM must never see stale pre-reset bus levels.
   always_ff @(posedge SLT_CLOCK) begin
      if (SLT_RESET) begin
         for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[N-1];

endmodule

// File: rtl/slot_access_capture.sv
// ---------------------------------------------------------------------------
// slot_access_capture
//  Front end of the PAC cartridge logic. Synchronises the MSX slot bus,
//  filters the strobes and emits one-cycle qualified write/read strobes with
//  the address and data of the access latched alongside.
//  Ports:
//   SLT_CLOCK     in   1       slot clock
//   SLT_RESET     in   1       synchronous, active-high reset
//   SLT_SLTSL     in   1       slot select, active low
//   SLT_WEn       in   1       write strobe, active low
//   SLT_RDn       in   1       read strobe, active low
//   SLT_A         in   ADDR_W  slot address
//   SLT_D         in   DATA_W  slot write data
//   acc_wr_stb    out  1       one-cycle pulse per qualified write
//   acc_rd_stb    out  1       one-cycle pulse per qualified read
//   acc_addr      out  ADDR_W  address of the last qualified access
//   acc_data      out  DATA_W  data of the last qualified write
//   acc_active    out  1       qualified access in progress
//   acc_conflict  out  1       one-cycle pulse: WEn and RDn both low while selected
// ---------------------------------------------------------------------------
module slot_access_capture
   import ese_pac_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 1,
   parameter int unsigned FILTER_CYC  = 1,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 8
) (
   input  logic              SLT_CLOCK,
   input  logic              SLT_RESET,
   input  logic              SLT_SLTSL,
   input  logic              SLT_WEn,
   input  logic              SLT_RDn,
   input  logic [ADDR_W-1:0] SLT_A,
   input  logic [DATA_W-1:0] SLT_D,
   output logic              acc_wr_stb,
   output logic              acc_rd_stb,
   output logic [ADDR_W-1:0] acc_addr,
   output logic [DATA_W-1:0] acc_data,
   output logic              acc_active,
   output logic              acc_conflict
);

   // Extra top bit "live" resets to 0 and shifts in 1: it marks that the
   // pipeline holds real bus samples rather than reset fill, so an access
   // already running at reset exit cannot look like a release.
   localparam int unsigned    SW       = 4 + ADDR_W + DATA_W;
   localparam logic [SW-1:0]  SYNC_RST = {1'b0, 3'b111, {ADDR_W{1'b0}}, {DATA_W{1'b0}}};
   localparam logic [2:0]     FILT     = 3'(FILTER_CYC);

   logic [SW-1:0]     sync_q;
   logic              live_s, sltsl_s, wen_s, rdn_s;
   logic [ADDR_W-1:0] a_s;
   logic [DATA_W-1:0] d_s;

   slot_sync #(
      .N       (SYNC_STAGES),
      .W       (SW),
      .RST_VAL (SYNC_RST)
   ) u_sync (
      .SLT_CLOCK (SLT_CLOCK),
      .SLT_RESET (SLT_RESET),
      .d         ({1'b1, SLT_SLTSL, SLT_WEn, SLT_RDn, SLT_A, SLT_D}),
      .q         (sync_q)
   );

   assign live_s  = sync_q[SW-1];
   assign sltsl_s = sync_q[SW-2];
   assign wen_s   = sync_q[SW-3];
   assign rdn_s   = sync_q[SW-4];
   assign a_s     = sync_q[ADDR_W+DATA_W-1:DATA_W];
   assign d_s     = sync_q[DATA_W-1:0];

   // Bus conditions on the synchronised samples.
   logic wr_cond, rd_cond, cf_cond, rel;
   assign wr_cond = ~sltsl_s & ~wen_s &  rdn_s;
   assign rd_cond = ~sltsl_s & ~rdn_s &  wen_s;
   assign cf_cond = ~sltsl_s & ~wen_s & ~rdn_s;
   assign rel     =  sltsl_s | (wen_s & rdn_s);

   pac_state_e        state_q, state_d;
   acc_type_e         type_q, type_d, cur_type;
   logic [2:0]        cnt_q, cnt_d, cnt_inc;
   logic              same_cond;
   logic              wr_stb_d, rd_stb_d, cf_d;
   logic              wr_stb_q, rd_stb_q, cf_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   assign cur_type  = wr_cond ? ACC_WR : ACC_RD;
   assign same_cond = (type_q == ACC_WR) ? wr_cond : rd_cond;
   assign cnt_inc   = cnt_q + 3'd1;

   // State and output registers.
   // NOTE: non-blocking assignments here so every flop samples pre-edge values.
   always_ff @(posedge SLT_CLOCK) begin
      if (SLT_RESET) begin
         state_q  <= ST_WAIT_REL;
         type_q   <= ACC_WR;
         cnt_q    <= 3'd0;
         wr_stb_q <= 1'b0;
         rd_stb_q <= 1'b0;
         cf_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         cnt_q    <= cnt_d;
         wr_stb_q <= wr_stb_d;
         rd_stb_q <= rd_stb_d;
         cf_q     <= cf_d;
         if (wr_stb_d || rd_stb_d) addr_q <= a_s;
         if (wr_stb_d)             data_q <= d_s;
      end
   end

   // Next-state logic.
   // NOTE: defaults first so every path assigns every output and no latch forms.
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cf_cond) begin
               state_d = ST_WAIT_REL;
               cnt_d   = 3'd0;
            end else if (wr_cond || rd_cond) begin
               type_d = cur_type;
               if (FILT == 3'd1) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = 3'd0;
               end else begin
                  state_d = ST_QUAL;
                  cnt_d   = 3'd1;
               end
            end
         end
         ST_QUAL: begin
            if (cf_cond) begin
               state_d = ST_WAIT_REL;
               cnt_d   = 3'd0;
            end else if (same_cond) begin
               if (cnt_inc == FILT) begin
                  state_d = ST_ACTIVE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               // Glitch or type change: drop the candidate without a strobe.
               state_d = ST_IDLE;
               cnt_d   = 3'd0;
            end
         end
         ST_ACTIVE: begin
            if (cf_cond)  state_d = ST_WAIT_REL;
            else if (rel) state_d = ST_IDLE;
         end
         ST_WAIT_REL: begin
            if (rel && live_s) state_d = ST_IDLE;
         end
         default: state_d = ST_WAIT_REL;
      endcase
   end

   // Output logic: strobes fire on the transition into ACTIVE, conflicts on
   // the transition into WAIT_REL; at most one of them per cycle.
   always_comb begin
      wr_stb_d = 1'b0;
      rd_stb_d = 1'b0;
      cf_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cf_cond) begin
               cf_d = 1'b1;
            end else if (FILT == 3'd1) begin
               wr_stb_d = wr_cond;
               rd_stb_d = rd_cond;
            end
         end
         ST_QUAL: begin
            if (cf_cond) begin
               cf_d = 1'b1;
            end else if (same_cond && (cnt_inc == FILT)) begin
               wr_stb_d = (type_q == ACC_WR);
               rd_stb_d = (type_q == ACC_RD);
            end
         end
         ST_ACTIVE: cf_d = cf_cond;
         default: ;
      endcase
   end

   assign acc_wr_stb   = wr_stb_q;
   assign acc_rd_stb   = rd_stb_q;
   assign acc_conflict = cf_q;
   assign acc_addr     = addr_q;
   assign acc_data     = data_q;
   assign acc_active   = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_slot_access_capture.sv
// ---------------------------------------------------------------------------
// tb_slot_access_capture
//  Two instances share one slot bus: dut0 with default parameters and dut1
//  with two sync stages and a three-sample filter. Each bus transaction is
//  scored per instance from the access rules (strobe iff the access is
//  selected and lasts at least FILTER_CYC cycles, conflict whenever both
//  strobes go low while selected); a monitor pops and compares on every
//  output pulse.
// ---------------------------------------------------------------------------
module tb_slot_access_capture;

   localparam int S1 = 2;
   localparam int F0 = 1;
   localparam int F1 = 3;

   localparam int K_WR   = 0;
   localparam int K_RD   = 1;
   localparam int K_CF   = 2;
   localparam int K_NONE = 3;

   typedef enum int {TR_WR, TR_RD, TR_CF, TR_WR_CF} tr_e;

   typedef struct {
      int          kind;
      logic [15:0] addr;
      logic [7:0]  data;
   } ev_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        sltsl = 1'b1;
   logic        wen   = 1'b1;
   logic        rdn   = 1'b1;
   logic [15:0] a     = '0;
   logic [7:0]  d     = '0;

   logic        wr0, rd0, act0, cf0, wr1, rd1, act1, cf1;
   logic [15:0] addr0, addr1;
   logic [7:0]  data0, data1;

   int checks = 0;
   int errors = 0;

   ev_t         q0[$];
   ev_t         q1[$];
   logic [15:0] m_addr [2];
   logic [7:0]  m_data [2];

   always #5 clk = ~clk;

   slot_access_capture dut0 (
      .SLT_CLOCK (clk), .SLT_RESET (rst), .SLT_SLTSL (sltsl), .SLT_WEn (wen),
      .SLT_RDn (rdn), .SLT_A (a), .SLT_D (d),
      .acc_wr_stb (wr0), .acc_rd_stb (rd0), .acc_addr (addr0), .acc_data (data0),
      .acc_active (act0), .acc_conflict (cf0)
   );

   slot_access_capture #(.SYNC_STAGES(S1), .FILTER_CYC(F1)) dut1 (
      .SLT_CLOCK (clk), .SLT_RESET (rst), .SLT_SLTSL (sltsl), .SLT_WEn (wen),
      .SLT_RDn (rdn), .SLT_A (a), .SLT_D (d),
      .acc_wr_stb (wr1), .acc_rd_stb (rd1), .acc_addr (addr1), .acc_data (data1),
      .acc_active (act1), .acc_conflict (cf1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void push(input int dn, input int kind, input logic [15:0] ad, input logic [7:0] dt);
      ev_t e;
      e.kind = kind;
      e.addr = ad;
      e.data = dt;
      if (dn == 0) q0.push_back(e);
      else         q1.push_back(e);
   endfunction

   // Expected outcome of one transaction for an instance with filter f.
   function automatic void model_access(input int dn, input int f, input tr_e tr, input bit sel,
                                        input int len, input int pre,
                                        input logic [15:0] ad, input logic [7:0] dt);
      if (sel) return;
      case (tr)
         TR_WR: if (len >= f) begin
            m_addr[dn] = ad;
            m_data[dn] = dt;
            push(dn, K_WR, ad, dt);
         end
         TR_RD: if (len >= f) begin
            m_addr[dn] = ad;
            push(dn, K_RD, ad, m_data[dn]);
         end
         TR_CF: push(dn, K_CF, m_addr[dn], m_data[dn]);
         TR_WR_CF: begin
            if (pre >= f) begin
               m_addr[dn] = ad;
               m_data[dn] = dt;
               push(dn, K_WR, ad, dt);
            end
            push(dn, K_CF, m_addr[dn], m_data[dn]);
         end
         default: ;
      endcase
   endfunction

   // One bus transaction followed by `gap` idle cycles (gap >= 1).
   task automatic access(input tr_e tr, input bit sel, input int len, input int pre,
                         input logic [15:0] ad, input logic [7:0] dt, input int gap);
      model_access(0, F0, tr, sel, len, pre, ad, dt);
      model_access(1, F1, tr, sel, len, pre, ad, dt);
      @(negedge clk);
      sltsl = sel;
      a     = ad;
      d     = dt;
      case (tr)
         TR_WR: begin wen = 1'b0; rdn = 1'b1; repeat (len) @(negedge clk); end
         TR_RD: begin wen = 1'b1; rdn = 1'b0; repeat (len) @(negedge clk); end
         TR_CF: begin wen = 1'b0; rdn = 1'b0; repeat (len) @(negedge clk); end
         TR_WR_CF: begin
            wen = 1'b0; rdn = 1'b1;
            repeat (pre) @(negedge clk);
            rdn = 1'b0;
            repeat (len) @(negedge clk);
         end
         default: ;
      endcase
      wen   = 1'b1;
      rdn   = 1'b1;
      sltsl = 1'($urandom_range(0, 1));
      a     = 16'($urandom);
      d     = 8'($urandom);
      repeat (gap - 1) @(negedge clk);
   endtask

   // Let outstanding strobes arrive, then confirm nothing is pending and
   // the held outputs match the model.
   task automatic drain(input string tag);
      repeat (S1 + F1 + 4) @(negedge clk);
      check({tag, " dut0 pending"}, q0.size(), 0);
      check({tag, " dut1 pending"}, q1.size(), 0);
      check({tag, " dut0 active"}, act0, 0);
      check({tag, " dut1 active"}, act1, 0);
      check({tag, " dut0 addr"}, addr0, m_addr[0]);
      check({tag, " dut0 data"}, data0, m_data[0]);
      check({tag, " dut1 addr"}, addr1, m_addr[1]);
      check({tag, " dut1 data"}, data1, m_data[1]);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " dut0 outs"}, {wr0, rd0, cf0, act0, addr0, data0}, 0);
      check({tag, " dut1 outs"}, {wr1, rd1, cf1, act1, addr1, data1}, 0);
   endtask

   task automatic mon(input int dn, input logic w, input logic r, input logic c, input logic act,
                      input logic [15:0] ad, input logic [7:0] dt);
      ev_t e;
      int  n;
      int  k;
      n = int'(w) + int'(r) + int'(c);
      if (n == 0) return;
      if (n > 1) begin
         check($sformatf("dut%0d pulses exclusive", dn), n, 1);
         return;
      end
      k = w ? K_WR : (r ? K_RD : K_CF);
      if ((dn == 0 && q0.size() == 0) || (dn == 1 && q1.size() == 0)) begin
         check($sformatf("dut%0d unexpected pulse kind", dn), k, K_NONE);
         return;
      end
      if (dn == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      check($sformatf("dut%0d pulse kind", dn), k, e.kind);
      check($sformatf("dut%0d acc_addr", dn), ad, e.addr);
      check($sformatf("dut%0d acc_data", dn), dt, e.data);
      check($sformatf("dut%0d acc_active", dn), act, (k != K_CF) ? 1 : 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, wr0, rd0, cf0, act0, addr0, data0);
         mon(1, wr1, rd1, cf1, act1, addr1, data1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Key A write held two cycles: dut0 strobes, dut1 filters it out.
      access(TR_WR, 1'b0, 2, 0, 16'h5FFE, 8'h4D, 3);
      drain("key_a_write");

      // Exactly FILTER_CYC of dut1 qualifies; one less does not.
      access(TR_WR, 1'b0, 3, 0, 16'h1234, 8'hA5, 2);
      access(TR_WR, 1'b0, 2, 0, 16'h2345, 8'h5A, 2);
      drain("filter_boundary");

      // Read keeps acc_data from the last write.
      access(TR_RD, 1'b0, 3, 0, 16'h4123, 8'hEE, 2);
      drain("read");

      // Both strobes low: conflict only.
      access(TR_CF, 1'b0, 4, 0, 16'h3333, 8'h33, 2);
      access(TR_WR_CF, 1'b0, 2, 4, 16'h5555, 8'h55, 2);
      drain("conflict");

      // Deselected long write is ignored; selected one strobes once.
      access(TR_WR, 1'b1, 6, 0, 16'h6000, 8'h11, 2);
      access(TR_WR, 1'b0, 6, 0, 16'h6001, 8'h22, 2);
      drain("sltsl");

      // Write in progress across reset release is never reported.
      @(negedge clk);
      rst   = 1'b1;
      sltsl = 1'b0;
      wen   = 1'b0;
      a     = 16'h7777;
      d     = 8'h77;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_mid_access");
      for (int i = 0; i < 2; i++) begin
         m_addr[i] = '0;
         m_data[i] = '0;
      end
      rst = 1'b0;
      repeat (8) @(negedge clk);
      wen = 1'b1;
      repeat (3) @(negedge clk);
      check("post_reset no dut0 strobe", q0.size() + int'(act0), 0);
      access(TR_WR, 1'b0, 4, 0, 16'h5FFF, 8'h69, 2);
      drain("key_b_after_reset");

      // Randomised transactions, back-to-back gaps included.
      for (int i = 0; i < 80; i++) begin
         access(tr_e'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                $urandom_range(1, 6), $urandom_range(1, 4),
                16'($urandom), 8'($urandom), $urandom_range(1, 4));
         if (i % 10 == 9) drain($sformatf("random_%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
